// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the InvMixColumns engine.
// Field polynomial x^8+x^4+x^3+x+1; multiples are built from xtime chains.
package aes_pkg;

    localparam int AES_NUM_COLS = 4;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    // Multiply by x (02) modulo the AES field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the fixed MixColumns constants (01/02/03/09/0b/0d/0e).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        case (m)
            8'h02:   r = x2;
            8'h03:   r = x2 ^ a;
            8'h09:   r = x8 ^ a;
            8'h0b:   r = x8 ^ x2 ^ a;
            8'h0d:   r = x8 ^ x4 ^ a;
            8'h0e:   r = x8 ^ x4 ^ x2;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns_seq_if.sv
// Handshake bundle for aes_inv_mix_columns_seq: input state channel and
// output state channel. mode_inv exists only when AES_INV_MIX_FWD_EN is defined.
interface aes_inv_mix_columns_seq_if import aes_pkg::*; ();

    logic       in_valid;
    logic       in_ready;
    aes_state_t state_in;
    logic       out_valid;
    logic       out_ready;
    aes_state_t state_out;
`ifdef AES_INV_MIX_FWD_EN
    logic       mode_inv;
`endif

    // Producer of blocks / consumer of results.
    modport master (
        output in_valid,
        output state_in,
        output out_ready,
`ifdef AES_INV_MIX_FWD_EN
        output mode_inv,
`endif
        input  in_ready,
        input  out_valid,
        input  state_out
    );

    // The transform engine.
    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
`ifdef AES_INV_MIX_FWD_EN
        input  mode_inv,
`endif
        output in_ready,
        output out_valid,
        output state_out
    );

endinterface

// File: rtl/aes_inv_mix_column_word.sv
// Combinational single-column (32-bit) InvMixColumns transform.
// With AES_INV_MIX_FWD_EN defined, mode_inv=0 selects forward MixColumns.
module aes_inv_mix_column_word import aes_pkg::*; (
`ifdef AES_INV_MIX_FWD_EN
    input  logic     mode_inv,
`endif
    input  aes_col_t col_in,
    output aes_col_t col_out
);

    logic [7:0] a0, a1, a2, a3;
    aes_col_t   inv_col;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Inverse matrix rows are rotations of [0e 0b 0d 09].
    always_comb begin
        inv_col[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        inv_col[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        inv_col[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        inv_col[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

`ifdef AES_INV_MIX_FWD_EN
    aes_col_t fwd_col;

    // Forward matrix rows are rotations of [02 03 01 01].
    always_comb begin
        fwd_col[31:24] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
        fwd_col[23:16] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
        fwd_col[15:8]  = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
        fwd_col[7:0]   = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    end

    assign col_out = mode_inv ? inv_col : fwd_col;
`else
    assign col_out = inv_col;
`endif

endmodule

// File: rtl/aes_inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: accepts one 128-bit column-major state,
// transforms COLS_PER_CYCLE columns per clock, then presents the result until
// the consumer takes it. Optional macro AES_INV_MIX_FWD_EN adds a per-block
// forward/inverse mode selected by mode_inv at accept.
module aes_inv_mix_columns_seq import aes_pkg::*; #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic                      clk,
    input logic                      rst,
    aes_inv_mix_columns_seq_if.slave bus
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] COL_STEP   = 2'(COLS_PER_CYCLE);
    localparam logic [2:0] COL_STEP_W = 3'(COLS_PER_CYCLE);

    logic [1:0] state;
    logic [1:0] col_idx;
    aes_state_t src_reg;
    aes_state_t dst_reg;
    logic       in_ready_int;
    logic       accept;
    logic       last_group;

    logic [1:0] grp_slot [COLS_PER_CYCLE];
    aes_col_t   grp_in   [COLS_PER_CYCLE];
    aes_col_t   grp_out  [COLS_PER_CYCLE];

`ifdef AES_INV_MIX_FWD_EN
    logic mode_reg;
`endif

    assign in_ready_int = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign accept       = bus.in_valid && in_ready_int;
    assign last_group   = ({1'b0, col_idx} + COL_STEP_W) == 3'(AES_NUM_COLS);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state == ST_DONE);
    // Gated so a half-written dst_reg is never visible on the bus.
    assign bus.state_out = (state == ST_DONE) ? dst_reg : '0;

    // Column group currently being transformed; col 0 occupies the MSBs.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign grp_slot[k] = col_idx + 2'(k);
        assign grp_in[k]   = src_reg[{~grp_slot[k], 5'b00000} +: 32];

        aes_inv_mix_column_word u_word (
`ifdef AES_INV_MIX_FWD_EN
            .mode_inv (mode_reg),
`endif
            .col_in   (grp_in[k]),
            .col_out  (grp_out[k])
        );
    end

    // Control FSM, source capture and per-group result writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            col_idx <= '0;
            src_reg <= '0;
            dst_reg <= '0;
`ifdef AES_INV_MIX_FWD_EN
            mode_reg <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        src_reg <= bus.state_in;
                        col_idx <= '0;
                        state   <= ST_BUSY;
`ifdef AES_INV_MIX_FWD_EN
                        mode_reg <= bus.mode_inv;
`endif
                    end
                end
                ST_BUSY: begin
                    for (int unsigned k = 0; k < unsigned'(COLS_PER_CYCLE); k++) begin
                        dst_reg[{~grp_slot[k], 5'b00000} +: 32] <= grp_out[k];
                    end
                    col_idx <= col_idx + COL_STEP;
                    if (last_group) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            src_reg <= bus.state_in;
                            col_idx <= '0;
                            state   <= ST_BUSY;
`ifdef AES_INV_MIX_FWD_EN
                            mode_reg <= bus.mode_inv;
`endif
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Self-checking bench for aes_inv_mix_columns_seq with instances at
// COLS_PER_CYCLE = 1, 2 and 4. Expected values come from a matrix-over-GF(2^8)
// reference model using generic shift-and-add field multiplication.
// Honours AES_INV_MIX_FWD_EN when defined.
module tb_aes_inv_mix_columns_seq;
    import aes_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_v   [3];
    aes_state_t st_in  [3];
    logic       o_rdy  [3];
    logic       mode_v [3];
    logic       in_rdy [3];
    logic       o_v    [3];
    aes_state_t st_out [3];

    int n_vec;
    int n_bad;

    localparam aes_state_t VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam aes_state_t VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_inv_mix_columns_seq_if bus ();

        assign bus.in_valid  = in_v[g];
        assign bus.state_in  = st_in[g];
        assign bus.out_ready = o_rdy[g];
`ifdef AES_INV_MIX_FWD_EN
        assign bus.mode_inv  = mode_v[g];
`endif
        assign in_rdy[g] = bus.in_ready;
        assign o_v[g]    = bus.out_valid;
        assign st_out[g] = bus.state_out;

        aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) product, shift-and-add with reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Column-wise matrix product; row r coefficient for byte j is base[(j-r) mod 4].
    function automatic aes_state_t model_mix(input aes_state_t s, input bit inv);
        logic [7:0] base [4];
        logic [7:0] acc;
        aes_state_t r;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], base[(j - row + 4) % 4]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic aes_state_t rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one block on instance s, wait for its result; lat counts edges after accept.
    task automatic send(input int s, input aes_state_t d, output int lat, output aes_state_t res);
        bit got;
        in_v[s]  = 1'b1;
        st_in[s] = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_rdy[s]) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed %b, required 1", s, in_rdy[s]);
            in_v[s] = 1'b0;
            lat = -1;
            res = '0;
            return;
        end
        @(posedge clk);
        #1;
        in_v[s] = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_v[s]) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL result_timeout dut%0d: out_valid stayed %b, required 1", s, o_v[s]);
            lat = -1;
        end
        res = st_out[s];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (o_v[s] !== 1'b0 || st_out[s] !== '0 || in_rdy[s] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: out_valid=%b state_out=%h in_ready=%b, required 0/0/0",
                         s, o_v[s], st_out[s], in_rdy[s]);
            end
        end
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (in_rdy[s] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release dut%0d: in_ready=%b, required 1", s, in_rdy[s]);
            end
        end
    endtask

    task automatic test_known_vector();
        int lat;
        aes_state_t res;
        for (int s = 0; s < 3; s++) begin
            send(s, VEC_IN, lat, res);
            n_vec++;
            if (res !== VEC_OUT) begin
                n_bad++;
                $display("FAIL known_vector dut%0d: got %h, required %h", s, res, VEC_OUT);
            end
            n_vec++;
            if (lat !== (4 >> s)) begin
                n_bad++;
                $display("FAIL latency dut%0d: got %0d, required %0d", s, lat, 4 >> s);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        aes_state_t d;
        aes_state_t res;
        aes_state_t exp;
        for (int n = 0; n < 1100; n++) begin
            int s;
            s = (n < 1000) ? 0 : ((n < 1050) ? 1 : 2);
            d = rand_state();
            exp = model_mix(d, 1'b1);
            send(s, d, lat, res);
            n_vec++;
            if (res !== exp) begin
                n_bad++;
                $display("FAIL random_inverse dut%0d: in %h got %h, required %h", s, d, res, exp);
            end
            n_vec++;
            if (model_mix(res, 1'b0) !== d) begin
                n_bad++;
                $display("FAIL round_trip dut%0d: forward(%h)=%h, required %h", s, res, model_mix(res, 1'b0), d);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit got;
        aes_state_t a;
        aes_state_t b;
        aes_state_t res;
        a = rand_state();
        b = rand_state();
        o_rdy[0] = 1'b0;
        send(0, a, lat, res);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (o_v[0] !== 1'b1 || in_rdy[0] !== 1'b0 || st_out[0] !== model_mix(a, 1'b1)) begin
                n_bad++;
                $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b state_out=%h, required 1/0/%h",
                         i, o_v[0], in_rdy[0], st_out[0], model_mix(a, 1'b1));
            end
        end
        in_v[0]  = 1'b1;
        st_in[0] = b;
        o_rdy[0] = 1'b1;
        #1;
        n_vec++;
        if (in_rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready: in_ready=%b, required 1", in_rdy[0]);
        end
        @(posedge clk);
        #1;
        in_v[0] = 1'b0;
        n_vec++;
        if (o_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL consume_and_accept: out_valid=%b, required 0", o_v[0]);
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_v[0]) got = 1'b1;
        end
        n_vec++;
        if (!got || lat != 4 || st_out[0] !== model_mix(b, 1'b1)) begin
            n_bad++;
            $display("FAIL back_to_back: valid=%b lat=%0d got %h, required 1/4/%h",
                     got, lat, st_out[0], model_mix(b, 1'b1));
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit got;
        aes_state_t a;
        aes_state_t b;
        a = rand_state();
        b = ~a;
        @(posedge clk);
        #1;
        in_v[0]  = 1'b1;
        st_in[0] = a;
        @(negedge clk);
        n_vec++;
        if (in_rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_ignore_ready: in_ready=%b, required 1", in_rdy[0]);
        end
        @(posedge clk);
        #1;
        st_in[0] = b;
        lat = 0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (in_rdy[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_in_ready cycle %0d: in_ready=%b, required 0", i, in_rdy[0]);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_v[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (o_v[0]) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        n_vec++;
        if (!got || lat != 4 || st_out[0] !== model_mix(a, 1'b1)) begin
            n_bad++;
            $display("FAIL busy_ignore_result: valid=%b lat=%0d got %h, required 1/4/%h",
                     got, lat, st_out[0], model_mix(a, 1'b1));
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (o_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore_idle: out_valid=%b, required 0", o_v[0]);
        end
    endtask

    task automatic test_reset_mid_busy();
        aes_state_t a;
        a = rand_state();
        in_v[0]  = 1'b1;
        st_in[0] = a;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (o_v[0] !== 1'b0 || st_out[0] !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_busy: out_valid=%b state_out=%h, required 0/0", o_v[0], st_out[0]);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_busy_ready: in_ready=%b, required 1", in_rdy[0]);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (o_v[0] !== 1'b0 || st_out[0] !== '0) begin
                n_bad++;
                $display("FAIL stale_output cycle %0d: out_valid=%b state_out=%h, required 0/0",
                         i, o_v[0], st_out[0]);
            end
        end
    endtask

`ifdef AES_INV_MIX_FWD_EN
    task automatic test_forward_mode();
        int lat;
        aes_state_t d;
        aes_state_t mid;
        aes_state_t res;
        mode_v[0] = 1'b0;
        send(0, VEC_OUT, lat, res);
        n_vec++;
        if (res !== VEC_IN) begin
            n_bad++;
            $display("FAIL forward_vector: got %h, required %h", res, VEC_IN);
        end
        for (int n = 0; n < 100; n++) begin
            int s;
            s = n % 3;
            d = rand_state();
            mode_v[s] = 1'b0;
            send(s, d, lat, mid);
            n_vec++;
            if (mid !== model_mix(d, 1'b0)) begin
                n_bad++;
                $display("FAIL forward_random dut%0d: got %h, required %h", s, mid, model_mix(d, 1'b0));
            end
            mode_v[s] = 1'b1;
            send(s, mid, lat, res);
            n_vec++;
            if (res !== d) begin
                n_bad++;
                $display("FAIL fwd_inv_identity dut%0d: got %h, required %h", s, res, d);
            end
        end
        for (int s = 0; s < 3; s++) mode_v[s] = 1'b1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_v[s]   = 1'b0;
            st_in[s]  = '0;
            o_rdy[s]  = 1'b1;
            mode_v[s] = 1'b1;
        end
        test_reset();
        @(posedge clk);
        #1;
        test_known_vector();
        test_random();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_busy();
`ifdef AES_INV_MIX_FWD_EN
        test_forward_mode();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
